payload_engine_sched: RTL and testbench

Packet-level sequencer for the bank of payload_engine regex engines. It accepts a byte stream with valid/ready/last. For each packet it:
- clears all engines via the shared sod line;
- steps them with en one byte per cycle;
- flushes the pipeline;
- snapshots the sticky per-engine match outputs;
- reports the hit engine IDs one per beat to the alert logic.

It sits between the packet-payload extractor and the char decoder/engine array.

---
 rtl/payload_engine_pkg.sv | 25 ++
 rtl/payload_lsb_enc.sv | 42 ++++
 rtl/payload_engine_sched.sv | 168 ++++++++++++++++
 tb/tb_payload_engine_sched.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/payload_engine_pkg.sv
// payload_engine_pkg
//   Shared types and helpers for the payload_engine packet sequencer.
//   - sched_state_t    : sequencer FSM states
//   - DRAIN_CYCLES_DEF : default flush length after the last byte
//   - eng_id_w()       : index width for a bank of N engines (minimum 1)
`timescale 1ns/1ps
package payload_engine_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SCAN,
    DRAIN,
    REPORT
  } sched_state_t;

  localparam int DRAIN_CYCLES_DEF = 2;

  // Width needed to index n items; never below 1 so single-entry banks
  // still get a real port.
  function automatic int eng_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/payload_lsb_enc.sv
// payload_lsb_enc
//   Lowest-set-bit priority encoder over the engine match vector.
//   Ports:
//     i_vec           in  NUM_ENG  vector to encode
//     o_index         out ID_W     index of lowest set bit (0 when none)
//     o_any           out 1        at least one bit set
//     o_onehot_single out 1        exactly one bit set
//   Purely combinational.
`timescale 1ns/1ps
module payload_lsb_enc
  import payload_engine_pkg::*;
#(
  parameter int NUM_ENG = 8,
  parameter int ID_W    = eng_id_w(NUM_ENG)
) (
  input  logic [NUM_ENG-1:0] i_vec,
  output logic [ID_W-1:0]    o_index,
  output logic               o_any,
  output logic               o_onehot_single
);

  logic [NUM_ENG-1:0] w_rest;

  // x & (x-1) drops the lowest set bit; anything left means >1 bits set.
  assign w_rest = i_vec & (i_vec - NUM_ENG'(1));

  // NOTE: every output gets a default before the loop, otherwise a
  // combinational block that only assigns on some paths infers latches.
  always_comb begin
    o_index = '0;
    o_any   = 1'b0;
    // Scan from the top down so the lowest set bit is written last and wins.
    for (int i = NUM_ENG - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_index = ID_W'(i);
        o_any   = 1'b1;
      end
    end
    o_onehot_single = o_any && (w_rest == '0);
  end

endmodule

// File: rtl/payload_engine_sched.sv
// payload_engine_sched
//   Packet-level sequencer for the payload_engine regex bank. Per packet it
//   clears the engines, steps them one byte per cycle, flushes the pipeline,
//   snapshots the sticky match vector and reports each hit engine ID as one
//   beat (or a single no-hit beat).
//   Ports:
//     clk, rst                          clock, async active-high reset
//     s_data/s_valid/s_last/s_ready     payload byte stream in
//     eng_data/eng_char_vld             byte + gate to the char decoder
//     eng_en/eng_sod                    engine clock enable / clear
//     eng_match                         sticky per-engine match outputs
//     m_id/m_hit/m_last/m_valid/m_ready report stream out
//     pkt_len                           saturating byte count
//     busy                              sequencer not idle
`timescale 1ns/1ps
module payload_engine_sched
  import payload_engine_pkg::*;
#(
  parameter int NUM_ENG      = 8,
  parameter int ID_W         = eng_id_w(NUM_ENG),
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int LEN_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [7:0]         eng_data,
  output logic               eng_char_vld,
  output logic               eng_en,
  output logic               eng_sod,
  input  logic [NUM_ENG-1:0] eng_match,
  output logic [ID_W-1:0]    m_id,
  output logic               m_hit,
  output logic               m_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [LEN_W-1:0]   pkt_len,
  output logic               busy
);

  localparam int            DC_W    = eng_id_w(DRAIN_CYCLES);
  localparam logic [DC_W-1:0] DC_INIT = DC_W'(DRAIN_CYCLES - 1);

  sched_state_t       r_state;
  sched_state_t       w_state_nxt;
  logic [DC_W-1:0]    r_drain_cnt;
  logic [NUM_ENG-1:0] r_pending;
  logic [LEN_W-1:0]   r_pkt_len;
  logic [ID_W-1:0]    r_m_id;
  logic               r_m_hit;
  logic               r_m_last;
  logic               r_m_valid;

  logic [ID_W-1:0]    w_idx;
  logic               w_any;
  logic               w_single;
  logic               w_accept;

  // r_pending holds the hits not yet presented; the encoder picks the next.
  payload_lsb_enc #(
    .NUM_ENG (NUM_ENG),
    .ID_W    (ID_W)
  ) u_lsb_enc (
    .i_vec           (r_pending),
    .o_index         (w_idx),
    .o_any           (w_any),
    .o_onehot_single (w_single)
  );

  assign w_accept = r_m_valid && m_ready;

  // Combinational so the engines are held clear for the whole reset too.
  assign eng_sod  = rst | (r_state == CLEAR);
  assign eng_data = s_data;
  assign busy     = (r_state != IDLE);
  assign pkt_len  = r_pkt_len;
  assign m_id     = r_m_id;
  assign m_hit    = r_m_hit;
  assign m_last   = r_m_last;
  assign m_valid  = r_m_valid;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    s_ready      = 1'b0;
    eng_en       = 1'b0;
    eng_char_vld = 1'b0;
    case (r_state)
      // The first byte stays on the bus until SCAN takes it.
      IDLE:  if (s_valid) w_state_nxt = CLEAR;
      CLEAR: w_state_nxt = SCAN;
      SCAN: begin
        s_ready      = 1'b1;
        eng_en       = s_valid;
        eng_char_vld = s_valid;
        if (s_valid && s_last) w_state_nxt = DRAIN;
      end
      // Engines keep stepping on a gated (all-low) char to flush the pipe.
      DRAIN: begin
        eng_en = 1'b1;
        if (r_drain_cnt == '0) w_state_nxt = REPORT;
      end
      REPORT: if (w_accept && r_m_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: no memories here, so every datapath register is cleared on reset,
  // including the pending snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drain_cnt <= '0;
      r_pending   <= '0;
      r_pkt_len   <= '0;
      r_m_id      <= '0;
      r_m_hit     <= 1'b0;
      r_m_last    <= 1'b0;
      r_m_valid   <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: r_pkt_len <= '0;
        SCAN: begin
          if (s_valid) begin
            if (r_pkt_len != '1) r_pkt_len <= r_pkt_len + LEN_W'(1);
            if (s_last)          r_drain_cnt <= DC_INIT;
          end
        end
        DRAIN: begin
          if (r_drain_cnt == '0) r_pending   <= eng_match;
          else                   r_drain_cnt <= r_drain_cnt - DC_W'(1);
        end
        REPORT: begin
          if (w_accept && r_m_last) begin
            r_m_valid <= 1'b0;
            r_m_hit   <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_id    <= '0;
          end else if (!r_m_valid || w_accept) begin
            // Load the next beat; its bit leaves r_pending as it is shown,
            // so "last" is simply "this was the only bit remaining".
            r_m_valid <= 1'b1;
            if (w_any) begin
              r_m_id    <= w_idx;
              r_m_hit   <= 1'b1;
              r_m_last  <= w_single;
              r_pending <= r_pending & ~(NUM_ENG'(1) << w_idx);
            end else begin
              r_m_id    <= '0;
              r_m_hit   <= 1'b0;
              r_m_last  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_payload_engine_sched.sv
// tb_payload_engine_sched
//   Directed bench for payload_engine_sched. Expected report beats are queued
//   when a packet is issued; a forked monitor pops and compares them on every
//   report handshake. LEN_W is shrunk to 3 so saturation is reachable.
`timescale 1ns/1ps
module tb_payload_engine_sched;
  import payload_engine_pkg::*;

  localparam int NUM_ENG      = 8;
  localparam int ID_W         = 3;
  localparam int DRAIN_CYCLES = 2;
  localparam int LEN_W        = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [7:0]         s_data;
  logic               s_valid;
  logic               s_last;
  logic               s_ready;
  logic [7:0]         eng_data;
  logic               eng_char_vld;
  logic               eng_en;
  logic               eng_sod;
  logic [NUM_ENG-1:0] eng_match;
  logic [ID_W-1:0]    m_id;
  logic               m_hit;
  logic               m_last;
  logic               m_valid;
  logic               m_ready;
  logic [LEN_W-1:0]   pkt_len;
  logic               busy;

  typedef struct packed {
    logic            hit;
    logic            last;
    logic [ID_W-1:0] id;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec   = 0;
  int    n_fail  = 0;
  int    en_cnt  = 0;
  int    sod_cnt = 0;

  always #5 clk = ~clk;

  payload_engine_sched #(
    .NUM_ENG      (NUM_ENG),
    .ID_W         (ID_W),
    .DRAIN_CYCLES (DRAIN_CYCLES),
    .LEN_W        (LEN_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .eng_data     (eng_data),
    .eng_char_vld (eng_char_vld),
    .eng_en       (eng_en),
    .eng_sod      (eng_sod),
    .eng_match    (eng_match),
    .m_id         (m_id),
    .m_hit        (m_hit),
    .m_last       (m_last),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .pkt_len      (pkt_len),
    .busy         (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_beat(input int id, input bit hit, input bit last);
    beat_t b;
    b.hit  = hit;
    b.last = last;
    b.id   = ID_W'(id);
    exp_q.push_back(b);
  endtask

  // Drives ncyc stimulus cycles (vmask bit k = s_valid in cycle k); the last
  // cycle carries s_last. Stops early once abort_at bytes/cycles are taken.
  task automatic drive_pkt(input logic [15:0] vmask, input int ncyc,
                           input int abort_at, input bit keep_valid);
    int k;
    int guard;
    k     = 0;
    guard = 0;
    while (k < ncyc && k != abort_at && guard < 200) begin
      s_valid = vmask[k];
      s_data  = 8'h30 + 8'(k);
      s_last  = (k == ncyc - 1);
      @(negedge clk);
      if (s_ready) begin
        check("eng_en_mirror", 32'(eng_en), 32'(s_valid));
        check("eng_char_vld_mirror", 32'(eng_char_vld), 32'(s_valid));
        check("eng_data", 32'(eng_data), 32'(s_data));
        k++;
      end
      guard++;
      @(posedge clk);
      #1;
    end
    if (guard >= 200) check("drive_timeout", 32'(guard), 32'd0);
    if (k == abort_at) return;
    s_last = 1'b0;
    if (keep_valid) begin
      s_data = 8'hA5;
    end else begin
      s_valid = 1'b0;
      @(negedge clk);
      check("drain_s_ready", 32'(s_ready), 32'd0);
      check("drain_eng_en", 32'(eng_en), 32'd1);
      check("drain_char_vld", 32'(eng_char_vld), 32'd0);
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("idle_reached", 32'(busy), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int e0;
    int s0;
    int guard;

    rst       = 1'b1;
    s_data    = 8'h00;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    eng_match = '0;
    m_ready   = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (eng_en)  en_cnt++;
          if (eng_sod) sod_cnt++;
          if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
              check("sb_unexpected_beat", 32'({m_hit, m_last, m_id}), 32'hFFFF_FFFF);
            end else begin
              beat_t e;
              e = exp_q.pop_front();
              check("report_beat", 32'({m_hit, m_last, m_id}), 32'(e));
            end
          end
        end
      end
    join_none

    // Reset state
    #2;
    check("rst_eng_sod", 32'(eng_sod), 32'd1);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_eng_sod", 32'(eng_sod), 32'd0);

    // Reset mid-SCAN after 5 of 10 bytes
    drive_pkt(16'hFFFF, 10, 5, 1'b0);
    check("mid_pkt_len", 32'(pkt_len), 32'd5);
    rst = 1'b1;
    #1;
    check("mid_rst_eng_sod", 32'(eng_sod), 32'd1);
    check("mid_rst_s_ready", 32'(s_ready), 32'd0);
    check("mid_rst_eng_en", 32'(eng_en), 32'd0);
    check("mid_rst_char_vld", 32'(eng_char_vld), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_pkt_len", 32'(pkt_len), 32'd0);
    check("mid_rst_m_out", 32'({m_valid, m_hit, m_last, m_id}), 32'd0);
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_s_ready", 32'(s_ready), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end

    // 3-byte packet, hits on engines 2 and 5
    @(posedge clk); #1;
    eng_match = 8'b0010_0100;
    push_beat(2, 1'b1, 1'b0);
    push_beat(5, 1'b1, 1'b1);
    e0 = en_cnt;
    s0 = sod_cnt;
    drive_pkt(16'h0007, 3, -1, 1'b0);
    wait_idle();
    check("p3_sod_cycles", 32'(sod_cnt - s0), 32'd1);
    check("p3_en_cycles", 32'(en_cnt - e0), 32'd5);
    check("p3_pkt_len", 32'(pkt_len), 32'd3);

    // No hits: single m_hit=0 beat
    @(posedge clk); #1;
    eng_match = '0;
    push_beat(0, 1'b0, 1'b1);
    drive_pkt(16'h0003, 2, -1, 1'b0);
    wait_idle();
    check("nohit_pkt_len", 32'(pkt_len), 32'd2);

    // Back-pressure during REPORT with pending = 1000_0001
    @(posedge clk); #1;
    eng_match = 8'b1000_0001;
    m_ready   = 1'b0;
    push_beat(0, 1'b1, 1'b0);
    push_beat(7, 1'b1, 1'b1);
    drive_pkt(16'h0001, 1, -1, 1'b0);
    guard = 0;
    while (!m_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("stall_beat_seen", 32'(m_valid), 32'd1);
    repeat (4) begin
      @(negedge clk);
      check("stall_hold", 32'({m_valid, m_hit, m_last, m_id}), 32'({1'b1, 1'b1, 1'b0, 3'd0}));
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_idle();

    // s_valid gaps: 1,0,0,1,1(last)
    @(posedge clk); #1;
    eng_match = 8'b0001_0000;
    push_beat(4, 1'b1, 1'b1);
    e0 = en_cnt;
    drive_pkt(16'h0019, 5, -1, 1'b0);
    wait_idle();
    check("gap_pkt_len", 32'(pkt_len), 32'd3);
    check("gap_en_cycles", 32'(en_cnt - e0), 32'd5);

    // pkt_len saturates at 7 for a 9-byte packet
    @(posedge clk); #1;
    eng_match = '0;
    push_beat(0, 1'b0, 1'b1);
    drive_pkt(16'h01FF, 9, -1, 1'b0);
    wait_idle();
    check("sat_pkt_len", 32'(pkt_len), 32'd7);

    // Back-to-back with s_valid held; second packet must be cleared
    @(posedge clk); #1;
    eng_match = 8'b0000_1000;
    push_beat(3, 1'b1, 1'b1);
    drive_pkt(16'h0003, 2, -1, 1'b1);
    s0 = sod_cnt;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!eng_sod && guard < 50);
    check("b2b_second_clear", 32'(eng_sod), 32'd1);
    @(posedge clk); #1;
    eng_match = '0;
    push_beat(0, 1'b0, 1'b1);
    drive_pkt(16'h0007, 3, -1, 1'b0);
    wait_idle();
    check("b2b_sod_cycles", 32'(sod_cnt - s0), 32'd1);
    check("b2b_pkt_len", 32'(pkt_len), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
